// File: rtl/ptw_pkg.sv
// Shared types and AXI constants for the page-table-walk PTE read responder.
package ptw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [2:0] AXSIZE_8B   = 3'd3;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      RESP_SLVERR, RESP_DECERR: return 1'b1;
      RESP_OKAY:                return 1'b0;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// One-entry request slot: holds a walker's PTE address until the arbiter takes it.
module ptw_req_slot #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  capture,
  input  logic                  flush,
  input  logic                  take,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= 1'b0;
      addr    <= '0;
    end else if (flush) begin
      // Flush beats a same-cycle capture: the request is cancelled before it exists.
      pending <= 1'b0;
    end else if (take) begin
      pending <= 1'b0;
    end else if (capture && !pending) begin
      // A capture into a full slot is a requester error and is dropped.
      pending <= 1'b1;
      addr    <= addr_in;
    end
  end

endmodule

// File: rtl/ptw_read_responder.sv
// Arbitrates ITLB/DTLB PTE reads onto a single-outstanding AXI4 read channel.
// Optional RRESP/RID/RLAST fault reporting is enabled by defining PTW_RESP_ERR_EN.
module ptw_read_responder
  import ptw_pkg::*;
#(
  parameter int                 ADDR_WIDTH = 64,
  parameter int                 DATA_WIDTH = 64,
  parameter int                 ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID    = 4'h2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  input  logic                  I_FLUSH,
  output logic                  I_DATA_VALID,
  output logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  D_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic                  D_FLUSH,
  output logic                  D_DATA_VALID,
  output logic [DATA_WIDTH-1:0] D_DATA,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [ID_WIDTH-1:0]   ARID,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic [ID_WIDTH-1:0]   RID
`ifdef PTW_RESP_ERR_EN
  ,
  output logic                  I_ACCESS_FAULT,
  output logic                  D_ACCESS_FAULT
`endif
);

  state_t                state_q, state_d;
  logic                  grant_q, rr_q, discard_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] i_data_q, d_data_q;

  logic                  i_pend, d_pend, i_take, d_take;
  logic [ADDR_WIDTH-1:0] i_slot_addr, d_slot_addr;
  logic                  i_req, d_req, any_req, grant_sel;
  logic                  owner_flush, discard_eff, resp_ok, beat_err;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
    .CLK     (CLK),
    .RST     (RST),
    .capture (I_ADDR_VALID),
    .flush   (I_FLUSH),
    .take    (i_take),
    .addr_in (I_ADDR),
    .pending (i_pend),
    .addr    (i_slot_addr)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
    .CLK     (CLK),
    .RST     (RST),
    .capture (D_ADDR_VALID),
    .flush   (D_FLUSH),
    .take    (d_take),
    .addr_in (D_ADDR),
    .pending (d_pend),
    .addr    (d_slot_addr)
  );

  // A slot being flushed this cycle is no longer a candidate for grant.
  assign i_req       = i_pend & ~I_FLUSH;
  assign d_req       = d_pend & ~D_FLUSH;
  assign any_req     = i_req | d_req;
  assign grant_sel   = (i_req & d_req) ? rr_q : d_req;
  assign owner_flush = (grant_q == PORT_D) ? D_FLUSH : I_FLUSH;
  assign discard_eff = discard_q | owner_flush;

`ifdef PTW_RESP_ERR_EN
  assign beat_err = resp_is_err(RRESP) | (RID != AXI_ID) | ~RLAST;
`else
  logic unused_r_sideband;
  assign unused_r_sideband = ^{RRESP, RLAST, RID};
  assign beat_err          = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    i_take  = 1'b0;
    d_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ADDR;
          i_take  = (grant_sel == PORT_I);
          d_take  = (grant_sel == PORT_D);
        end
      end
      ADDR:    if (ARREADY) state_d = DATA;
      DATA:    if (RVALID)  state_d = discard_eff ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      grant_q   <= PORT_D;
      rr_q      <= PORT_D;
      discard_q <= 1'b0;
      araddr_q  <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (any_req) begin
          grant_q   <= grant_sel;
          araddr_q  <= (grant_sel == PORT_D) ? d_slot_addr : i_slot_addr;
          discard_q <= 1'b0;
          // The pointer only moves when both walkers actually contended.
          if (i_req && d_req) rr_q <= ~grant_sel;
        end
      end else if (owner_flush) begin
        discard_q <= 1'b1;
      end
      if (state_q == DATA && RVALID && !discard_eff) begin
        if (grant_q == PORT_D) d_data_q <= beat_err ? '0 : RDATA;
        else                   i_data_q <= beat_err ? '0 : RDATA;
      end
    end
  end

`ifdef PTW_RESP_ERR_EN
  logic fault_q;
  always_ff @(posedge CLK) begin
    if (RST)                                          fault_q <= 1'b0;
    else if (state_q == DATA && RVALID && !discard_eff) fault_q <= beat_err;
  end
  assign I_ACCESS_FAULT = I_DATA_VALID & fault_q;
  assign D_ACCESS_FAULT = D_DATA_VALID & fault_q;
`endif

  assign resp_ok      = (state_q == RESP) & ~discard_eff;
  assign I_DATA_VALID = resp_ok & (grant_q == PORT_I);
  assign D_DATA_VALID = resp_ok & (grant_q == PORT_D);
  assign I_DATA       = i_data_q;
  assign D_DATA       = d_data_q;

  assign ARVALID = (state_q == ADDR);
  assign RREADY  = (state_q == DATA);
  assign ARADDR  = araddr_q;
  assign ARID    = AXI_ID;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = AXSIZE_8B;
  assign ARBURST = BURST_INCR;

endmodule

// File: tb/tb_ptw_read_responder.sv
// Directed bench for ptw_read_responder; define PTW_RESP_ERR_EN to cover fault reporting.
module tb_ptw_read_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_ADDR_VALID, I_FLUSH, D_ADDR_VALID, D_FLUSH;
  logic [63:0] I_ADDR, D_ADDR;
  logic        I_DATA_VALID, D_DATA_VALID;
  logic [63:0] I_DATA, D_DATA;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [63:0] ARADDR, RDATA;
  logic [3:0]  ARID, RID;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;
`ifdef PTW_RESP_ERR_EN
  logic        I_ACCESS_FAULT, D_ACCESS_FAULT;
`endif

  int total = 0;
  int bad   = 0;
  int i_dv_cnt = 0;
  int d_dv_cnt = 0;
  int ar_cnt   = 0;

  always #5 CLK = ~CLK;

  ptw_read_responder dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_ADDR_VALID (I_ADDR_VALID),
    .I_ADDR       (I_ADDR),
    .I_FLUSH      (I_FLUSH),
    .I_DATA_VALID (I_DATA_VALID),
    .I_DATA       (I_DATA),
    .D_ADDR_VALID (D_ADDR_VALID),
    .D_ADDR       (D_ADDR),
    .D_FLUSH      (D_FLUSH),
    .D_DATA_VALID (D_DATA_VALID),
    .D_DATA       (D_DATA),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .ARADDR       (ARADDR),
    .ARID         (ARID),
    .ARLEN        (ARLEN),
    .ARSIZE       (ARSIZE),
    .ARBURST      (ARBURST),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RLAST        (RLAST),
    .RID          (RID)
`ifdef PTW_RESP_ERR_EN
    ,
    .I_ACCESS_FAULT (I_ACCESS_FAULT),
    .D_ACCESS_FAULT (D_ACCESS_FAULT)
`endif
  );

  always @(posedge CLK) begin
    if (!RST) begin
      if (I_DATA_VALID)      i_dv_cnt <= i_dv_cnt + 1;
      if (D_DATA_VALID)      d_dv_cnt <= d_dv_cnt + 1;
      if (ARVALID && ARREADY) ar_cnt  <= ar_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Current cycle is ADDR with ARREADY=1: check AR, then return one R beat next cycle.
  task automatic serve(input string tag, input logic [63:0] exp_addr, input logic [63:0] rdata);
    check({tag, "_arvalid"}, ARVALID, 1);
    check({tag, "_araddr"}, ARADDR, exp_addr);
    cyc();
    check({tag, "_rready"}, RREADY, 1);
    RVALID = 1'b1;
    RDATA  = rdata;
    cyc();
    RVALID = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    I_ADDR_VALID = 0; I_ADDR = 0; I_FLUSH = 0;
    D_ADDR_VALID = 0; D_ADDR = 0; D_FLUSH = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 2'b00; RLAST = 1'b1; RID = 4'h2;
    cyc(); cyc();

    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_i_dv", I_DATA_VALID, 0);
    check("rst_d_dv", D_DATA_VALID, 0);
    check("rst_i_data", I_DATA, 0);
    check("rst_d_data", D_DATA, 0);
    check("rst_araddr", ARADDR, 0);
    check("const_arlen", ARLEN, 0);
    check("const_arsize", ARSIZE, 3);
    check("const_arburst", ARBURST, 1);
    check("const_arid", ARID, 4'h2);
    RST = 1'b0;

    // Single D request, nominal latency: pulse in cycle 0, AR in 2, data-valid in 4.
    D_ADDR_VALID = 1; D_ADDR = 64'h0000_0000_8000_1008; ARREADY = 1;
    cyc();
    D_ADDR_VALID = 0;
    check("t1_c1_arvalid", ARVALID, 0);
    cyc();
    check("t1_arlen", ARLEN, 0);
    check("t1_arsize", ARSIZE, 3);
    serve("t1", 64'h0000_0000_8000_1008, 64'h0000_0000_2000_00CF);
    check("t1_d_dv", D_DATA_VALID, 1);
    check("t1_d_data", D_DATA, 64'h0000_0000_2000_00CF);
    check("t1_i_dv", I_DATA_VALID, 0);
    cyc();
    check("t1_d_dv_end", D_DATA_VALID, 0);
    check("t1_d_data_hold", D_DATA, 64'h0000_0000_2000_00CF);
    check("t1_d_cnt", d_dv_cnt, 1);

    // Contention: rr starts at D, so D first, then I.
    I_ADDR_VALID = 1; I_ADDR = 64'h1000;
    D_ADDR_VALID = 1; D_ADDR = 64'h2000;
    cyc();
    I_ADDR_VALID = 0; D_ADDR_VALID = 0;
    cyc();
    serve("t2a", 64'h2000, 64'hD2);
    check("t2a_d_dv", D_DATA_VALID, 1);
    check("t2a_i_dv", I_DATA_VALID, 0);
    check("t2a_d_data", D_DATA, 64'hD2);
    cyc();
    cyc();
    serve("t2b", 64'h1000, 64'h11);
    check("t2b_i_dv", I_DATA_VALID, 1);
    check("t2b_d_dv", D_DATA_VALID, 0);
    check("t2b_i_data", I_DATA, 64'h11);
    check("t2b_d_data_hold", D_DATA, 64'hD2);
    // Repeat contention, captured during RESP: rr now points at I.
    I_ADDR_VALID = 1; D_ADDR_VALID = 1;
    cyc();
    I_ADDR_VALID = 0; D_ADDR_VALID = 0;
    cyc();
    serve("t2c", 64'h1000, 64'h12);
    check("t2c_i_dv", I_DATA_VALID, 1);
    check("t2c_i_data", I_DATA, 64'h12);
    cyc();
    cyc();
    serve("t2d", 64'h2000, 64'h22);
    check("t2d_d_dv", D_DATA_VALID, 1);
    check("t2d_d_data", D_DATA, 64'h22);
    cyc();
    check("t2_i_cnt", i_dv_cnt, 2);
    check("t2_d_cnt", d_dv_cnt, 3);

    // AR stall: ARVALID/ARADDR hold for 5 cycles of ARREADY=0.
    ARREADY = 0;
    D_ADDR_VALID = 1; D_ADDR = 64'h3000;
    cyc();
    D_ADDR_VALID = 0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_stall%0d_arvalid", k), ARVALID, 1);
      check($sformatf("t3_stall%0d_araddr", k), ARADDR, 64'h3000);
      cyc();
    end
    ARREADY = 1;
    check("t3_hs_arvalid", ARVALID, 1);
    cyc();
    check("t3_rready", RREADY, 1);
    check("t3_d_dv_early", D_DATA_VALID, 0);
    cyc();
    RVALID = 1; RDATA = 64'h33;
    cyc();
    RVALID = 0;
    check("t3_d_dv", D_DATA_VALID, 1);
    check("t3_d_data", D_DATA, 64'h33);
    cyc();

    // Flush of D while in DATA: beat drained silently, pending I then issued.
    D_ADDR_VALID = 1; D_ADDR = 64'h4000;
    cyc();
    D_ADDR_VALID = 0;
    I_ADDR_VALID = 1; I_ADDR = 64'h5000;
    cyc();
    I_ADDR_VALID = 0;
    check("t4_araddr", ARADDR, 64'h4000);
    cyc();
    D_FLUSH = 1;
    cyc();
    D_FLUSH = 0;
    check("t4_rready", RREADY, 1);
    RVALID = 1; RDATA = 64'hDEAD;
    cyc();
    RVALID = 0;
    check("t4_d_dv", D_DATA_VALID, 0);
    check("t4_rready_done", RREADY, 0);
    cyc();
    check("t4_d_data_hold", D_DATA, 64'h33);
    serve("t4i", 64'h5000, 64'h55);
    check("t4_i_dv", I_DATA_VALID, 1);
    check("t4_i_data", I_DATA, 64'h55);
    cyc();
    check("t4_d_cnt", d_dv_cnt, 4);

    // Second D pulse while the D slot is full is dropped.
    ARREADY = 0;
    I_ADDR_VALID = 1; I_ADDR = 64'h6000;
    cyc();
    I_ADDR_VALID = 0;
    D_ADDR_VALID = 1; D_ADDR = 64'h2000;
    cyc();
    D_ADDR = 64'h3000;
    cyc();
    D_ADDR_VALID = 0;
    check("t5_araddr_i", ARADDR, 64'h6000);
    cyc();
    ARREADY = 1;
    serve("t5i", 64'h6000, 64'h66);
    check("t5_i_dv", I_DATA_VALID, 1);
    cyc();
    cyc();
    serve("t5d", 64'h2000, 64'h77);
    check("t5_d_dv", D_DATA_VALID, 1);
    check("t5_d_data", D_DATA, 64'h77);
    cyc();
    check("t5_idle_arvalid0", ARVALID, 0);
    cyc();
    check("t5_idle_arvalid1", ARVALID, 0);
    check("t5_d_cnt", d_dv_cnt, 5);
    check("t5_i_cnt", i_dv_cnt, 4);
    check("t5_ar_cnt", ar_cnt, 10);

    // Response error on an I request.
    I_ADDR_VALID = 1; I_ADDR = 64'h9000; RRESP = 2'b11;
    cyc();
    I_ADDR_VALID = 0;
    cyc();
    serve("t6", 64'h9000, 64'hBEEF);
    check("t6_i_dv", I_DATA_VALID, 1);
`ifdef PTW_RESP_ERR_EN
    check("t6_i_fault", I_ACCESS_FAULT, 1);
    check("t6_d_fault", D_ACCESS_FAULT, 0);
    check("t6_i_data", I_DATA, 0);
`else
    check("t6_i_data", I_DATA, 64'hBEEF);
`endif
    RRESP = 2'b00;
    cyc();

    // Reset while in ADDR abandons the transaction.
    ARREADY = 0;
    D_ADDR_VALID = 1; D_ADDR = 64'h8000;
    cyc();
    D_ADDR_VALID = 0;
    cyc();
    check("t7_addr_arvalid", ARVALID, 1);
    RST = 1;
    cyc();
    check("t7_rst_arvalid", ARVALID, 0);
    check("t7_rst_araddr", ARADDR, 0);
    check("t7_rst_d_data", D_DATA, 0);
    RST = 0;
    cyc();
    check("t7_post_arvalid", ARVALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
